fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side pointer and full-flag controller for the asynchronous FIFO, directly upstream of the dual-port memory buffer. It accepts write requests from the producer, qualifies them against the full condition, and drives the memory's binary write address and write-accept strobe. It also publishes a Gray-coded write pointer for the read domain. It synchronizes the read domain's Gray pointer into the write clock domain for full detection.

## Interface
Parameters (from package `definitions`):
- DATASIZE, package value: data width; not used internally, kept for package consistency.
- ADDRSIZE, package value, minimum 2: address width; DEPTH = 1<<ADDRSIZE.
- AFULL_THRESH, default 2: free-slot threshold for almost-full. Present only when `WAFULL_EN` is defined.

Ports:
- wclk  in  1  write clock. One clock only.
- wrst  in  1  reset. Synchronous, active-high.
- wreq  in  1  producer write request.
- rptr_gray  in  ADDRSIZE+1  Gray-coded read pointer, sourced from the read clock domain.
- wack  out  1  write accepted: wreq & ~wfull. Combinational; drives the memory write enable.
- waddr  out  ADDRSIZE  registered binary write address.
- wptr_gray  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
- wfull  out  1  registered full flag.
- wafull  out  1  registered almost-full flag. Present only with `WAFULL_EN`.

## Operation
- Internal binary pointer wbin is ADDRSIZE+1 bits; waddr = wbin[ADDRSIZE-1:0].
- wbin_next = wbin + wack, computed modulo 2^(ADDRSIZE+1).
- wgray_next = (wbin_next>>1) ^ wbin_next.
- Every wclk edge: wbin <= wbin_next, wptr_gray <= wgray_next.
- Synchronizer: rptr_gray passes through two flops, q1 then wq2_rptr, each reset to 0.
- Full: wfull <= (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- wreq while wfull=1: wack=0, and the pointers, waddr and wptr_gray hold. No error is flagged.
- Wrap-around: the MSB of wbin toggles every DEPTH accepted writes; waddr wraps from DEPTH-1 to 0.
- wfull is pessimistic: it may stay set up to 3 edges after the read pointer advances. It is never late in asserting.
- Reset, including mid-operation with wfull=1: on the next edge, wbin, wptr_gray, waddr, both sync flops, wfull and wafull all become 0.
- wack is 0 while wrst=1.

## Timing
- wack follows wreq in the same cycle; the address for that write is the current waddr.
- waddr and wptr_gray advance at the edge on which wack=1.
- wfull asserts at the same edge as the DEPTH-th outstanding accept. The very next cycle's wreq is therefore refused.
- A rptr_gray change before edge k is seen in wq2_rptr after edge k+1 and in wfull/wafull after edge k+2.
- Reset values: wack=0, waddr=0, wptr_gray=0, wfull=0, wafull=0.

## Configuration
- `WAFULL_EN` defined:
  - wq2_rptr is converted Gray-to-binary to give wq2_rbin.
  - Fill level: used = wbin_next - wq2_rbin, ADDRSIZE+1 bits, modulo arithmetic.
  - wafull <= (used >= DEPTH - AFULL_THRESH); registered, reset to 0.
- `WAFULL_EN` undefined: the wafull port, the AFULL_THRESH parameter and the Gray-to-binary logic are all absent. All other behaviour is identical.

## Structure
- Package `definitions`: DATASIZE and ADDRSIZE, plus a localparam DEPTH derived from ADDRSIZE.
- Package functions: bin2gray and gray2bin, each on ADDRSIZE+1 bits.
- Sub-module `sync_r2w`: the two-flop synchronizer (wclk, wrst, d in, q out, width ADDRSIZE+1). It is reused by the mirrored read-side controller.

## Test plan
All scenarios use ADDRSIZE=4, so DEPTH=16.
- Reset: wrst=1 for 2 edges with wreq=1 → wack=0, waddr=0, wptr_gray=0x00, wfull=0 throughout.
- Fill: rptr_gray=0, 16 consecutive wreq → waddr steps 0..15 then 0; wfull=1 after the 16th accept edge. A 17th wreq gives wack=0, waddr stays 0 and wptr_gray stays 0x18.
- Release: from full, set rptr_gray=0x01 → wfull=0 after the third wclk edge. The next wreq gives wack=1 and waddr=0 → 1.
- Wrap: 40 writes interleaved with rptr_gray tracking gray(writes-4) → wfull never asserts; wptr_gray sequence after accepts 15, 16, 31, 32 is 0x08, 0x18, 0x10, 0x00.
- Reset mid-operation: wfull=1, wrst pulsed for 1 edge → all outputs 0 and wack=wreq next cycle.
- `WAFULL_EN`, AFULL_THRESH=2, rptr_gray=0 → wafull=0 after 13 accepts, 1 after 14; wfull=1 after 16.

Source files
------------

// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared sizing and pointer-coding helpers for the async FIFO write/read controllers.
package definitions;

    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 1 << ADDRSIZE;
    localparam int PTRW     = ADDRSIZE + 1;

    typedef logic [PTRW-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTRW-1] = gray[PTRW-1];
        for (int i = PTRW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_sync_r2w.sv
// Two-flop synchronizer bringing a Gray pointer into the local clock domain.
module sync_r2w
    import definitions::*;
#(
    parameter int WIDTH = PTRW
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and full-flag controller of the async FIFO.
// Optional almost-full output is enabled with the WAFULL_EN macro.
module fifo_wr_ctrl
    import definitions::*;
`ifdef WAFULL_EN
#(
    parameter int unsigned AFULL_THRESH = 2
)
`endif
(
    input  logic                wclk,
    input  logic                wrst,
    input  logic                wreq,
    input  logic [ADDRSIZE:0]   rptr_gray,
    output logic                wack,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr_gray,
`ifdef WAFULL_EN
    output logic                wafull,
`endif
    output logic                wfull
);

    ptr_t wbin_q;
    ptr_t wbin_d;
    ptr_t wgray_q;
    ptr_t wgray_d;
    ptr_t wq2_rptr;
    logic wfull_q;
    logic wfull_d;

    sync_r2w #(
        .WIDTH (PTRW)
    ) u_sync_r2w (
        .wclk (wclk),
        .wrst (wrst),
        .d    (rptr_gray),
        .q    (wq2_rptr)
    );

    assign wack = wreq & ~wfull_q & ~wrst;

    // Full when the next write pointer has lapped the synchronized read pointer:
    // top two Gray bits inverted, remaining bits equal.
    always_comb begin
        wbin_d  = wbin_q + PTRW'(wack);
        wgray_d = bin2gray(wbin_d);
        wfull_d = (wgray_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            wfull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            wfull_q <= wfull_d;
        end
    end

`ifdef WAFULL_EN
    ptr_t wq2_rbin;
    ptr_t used;
    logic wafull_q;
    logic wafull_d;

    always_comb begin
        wq2_rbin = gray2bin(wq2_rptr);
        used     = wbin_d - wq2_rbin;
        wafull_d = (int'(used) >= (DEPTH - int'(AFULL_THRESH)));
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= wafull_d;
        end
    end

    assign wafull = wafull_q;
`endif

    assign waddr     = wbin_q[ADDRSIZE-1:0];
    assign wptr_gray = wgray_q;
    assign wfull     = wfull_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios plus random traffic
// checked against an occupancy-count model of the FIFO write side.
module tb_fifo_wr_ctrl;

    localparam int AW    = 4;
    localparam int DEP   = 16;
    localparam int ATHR  = 2;

    logic          wclk;
    logic          wrst;
    logic          wreq;
    logic [AW:0]   rptr_gray;
    logic          wack;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr_gray;
    logic          wfull;
`ifdef WAFULL_EN
    logic          wafull;
`endif

    int passes;
    int total;

    // Model state: counts of writes accepted and reads done, plus the read
    // count as seen through the two-stage synchronizer.
    int wcnt;
    int rcnt;
    int s1;
    int s2;
    bit mfull;
    bit mafull;
    bit expWack;
    logic obsWack;

    fifo_wr_ctrl dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .wreq      (wreq),
        .rptr_gray (rptr_gray),
        .wack      (wack),
        .waddr     (waddr),
        .wptr_gray (wptr_gray),
`ifdef WAFULL_EN
        .wafull    (wafull),
`endif
        .wfull     (wfull)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [AW:0] grayOf(input int n);
        logic [AW:0] v;
        v = (AW+1)'(n % (2 * DEP));
        return v ^ (v >> 1);
    endfunction

    // One write-clock cycle: drive inputs, sample wack before the edge,
    // then advance the model across the edge.
    task automatic applyStimulus(input bit req, input bit rst, input int rc);
        int used;
        @(negedge wclk);
        wreq      = req;
        wrst      = rst;
        rcnt      = rc;
        rptr_gray = grayOf(rc);
        #1;
        expWack = req && !rst && !mfull;
        obsWack = wack;
        @(posedge wclk);
        if (rst) begin
            wcnt = 0; s1 = 0; s2 = 0; mfull = 0; mafull = 0;
        end else begin
            wcnt  = wcnt + int'(expWack);
            used  = (((wcnt - s2) % (2 * DEP)) + 2 * DEP) % (2 * DEP);
            mfull  = (used == DEP);
            mafull = (used >= DEP - ATHR);
            s2 = s1;
            s1 = rcnt;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 0);
            total++; if (obsWack !== 1'b0) $display("FAIL reset_wack: got %b want 0", obsWack); else passes++;
            total++; if (waddr !== '0) $display("FAIL reset_waddr: got %h want 0", waddr); else passes++;
            total++; if (wptr_gray !== '0) $display("FAIL reset_gray: got %h want 00", wptr_gray); else passes++;
            total++; if (wfull !== 1'b0) $display("FAIL reset_wfull: got %b want 0", wfull); else passes++;
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEP; i++) begin
            total++; if (waddr !== AW'(i - 1)) $display("FAIL fill_addr_pre: got %h want %h", waddr, i - 1); else passes++;
            applyStimulus(1'b1, 1'b0, 0);
            total++; if (obsWack !== 1'b1) $display("FAIL fill_wack: got %b want 1", obsWack); else passes++;
            total++; if (wfull !== (i == DEP)) $display("FAIL fill_wfull: got %b want %b (accept %0d)", wfull, i == DEP, i); else passes++;
        end
        total++; if (waddr !== 4'h0) $display("FAIL fill_wrap_addr: got %h want 0", waddr); else passes++;
        applyStimulus(1'b1, 1'b0, 0);
        total++; if (obsWack !== 1'b0) $display("FAIL fill_refuse_wack: got %b want 0", obsWack); else passes++;
        total++; if (waddr !== 4'h0) $display("FAIL fill_refuse_addr: got %h want 0", waddr); else passes++;
        total++; if (wptr_gray !== 5'h18) $display("FAIL fill_refuse_gray: got %h want 18", wptr_gray); else passes++;
    endtask

    task automatic test_release();
        for (int e = 1; e <= 3; e++) begin
            applyStimulus(1'b0, 1'b0, 1);
            total++; if (wfull !== (e < 3)) $display("FAIL release_wfull: got %b want %b (edge %0d)", wfull, e < 3, e); else passes++;
        end
        applyStimulus(1'b1, 1'b0, 1);
        total++; if (obsWack !== 1'b1) $display("FAIL release_wack: got %b want 1", obsWack); else passes++;
        total++; if (waddr !== 4'h1) $display("FAIL release_addr: got %h want 1", waddr); else passes++;
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (!mfull && guard < 40) begin
            applyStimulus(1'b1, 1'b0, rcnt);
            guard++;
        end
        total++; if (wfull !== 1'b1) $display("FAIL midreset_prefull: got %b want 1", wfull); else passes++;
        applyStimulus(1'b1, 1'b1, 0);
        total++; if (obsWack !== 1'b0) $display("FAIL midreset_wack_in_reset: got %b want 0", obsWack); else passes++;
        total++; if ({waddr, wptr_gray, wfull} !== '0) $display("FAIL midreset_outputs: got addr %h gray %h full %b want 0", waddr, wptr_gray, wfull); else passes++;
        applyStimulus(1'b1, 1'b0, 0);
        total++; if (obsWack !== 1'b1) $display("FAIL midreset_wack_after: got %b want 1", obsWack); else passes++;
    endtask

    task automatic test_wrap();
        logic [AW:0] g15, g16, g31, g32;
        bit sawFull;
        g15 = 'x; g16 = 'x; g31 = 'x; g32 = 'x;
        sawFull = 0;
        applyStimulus(1'b0, 1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, (wcnt >= 4) ? wcnt - 4 : 0);
            if (wfull) sawFull = 1;
            if (wcnt == 15) g15 = wptr_gray;
            if (wcnt == 16) g16 = wptr_gray;
            if (wcnt == 31) g31 = wptr_gray;
            if (wcnt == 32) g32 = wptr_gray;
        end
        total++; if (sawFull !== 1'b0) $display("FAIL wrap_nofull: got %b want 0", sawFull); else passes++;
        total++; if (wcnt != 40) $display("FAIL wrap_count: got %0d want 40", wcnt); else passes++;
        total++; if (g15 !== 5'h08) $display("FAIL wrap_g15: got %h want 08", g15); else passes++;
        total++; if (g16 !== 5'h18) $display("FAIL wrap_g16: got %h want 18", g16); else passes++;
        total++; if (g31 !== 5'h10) $display("FAIL wrap_g31: got %h want 10", g31); else passes++;
        total++; if (g32 !== 5'h00) $display("FAIL wrap_g32: got %h want 00", g32); else passes++;
    endtask

    task automatic test_random();
        int rc;
        applyStimulus(1'b0, 1'b1, 0);
        for (int i = 0; i < 400; i++) begin
            rc = rcnt;
            if (($urandom % 4) == 0 && rc < wcnt) rc = rc + int'($urandom_range(1, wcnt - rc));
            applyStimulus(($urandom % 4) != 0, ($urandom % 97) == 0, rc);
            if (wrst) rcnt = 0;
            total++; if (obsWack !== expWack) $display("FAIL rand_wack: got %b want %b (cyc %0d)", obsWack, expWack, i); else passes++;
            total++; if (waddr !== AW'(wcnt % DEP)) $display("FAIL rand_waddr: got %h want %h (cyc %0d)", waddr, wcnt % DEP, i); else passes++;
            total++; if (wptr_gray !== grayOf(wcnt)) $display("FAIL rand_gray: got %h want %h (cyc %0d)", wptr_gray, grayOf(wcnt), i); else passes++;
            total++; if (wfull !== mfull) $display("FAIL rand_wfull: got %b want %b (cyc %0d)", wfull, mfull, i); else passes++;
`ifdef WAFULL_EN
            total++; if (wafull !== mafull) $display("FAIL rand_wafull: got %b want %b (cyc %0d)", wafull, mafull, i); else passes++;
`endif
        end
    endtask

`ifdef WAFULL_EN
    task automatic test_wafull();
        applyStimulus(1'b0, 1'b1, 0);
        for (int i = 1; i <= DEP; i++) begin
            applyStimulus(1'b1, 1'b0, 0);
            if (i == 13) begin
                total++; if (wafull !== 1'b0) $display("FAIL wafull_13: got %b want 0", wafull); else passes++;
            end
            if (i == 14) begin
                total++; if (wafull !== 1'b1) $display("FAIL wafull_14: got %b want 1", wafull); else passes++;
            end
        end
        total++; if (wfull !== 1'b1) $display("FAIL wafull_full16: got %b want 1", wfull); else passes++;
    endtask
`endif

    initial begin
        passes = 0; total = 0;
        wcnt = 0; rcnt = 0; s1 = 0; s2 = 0; mfull = 0; mafull = 0;
        wreq = 1'b0; wrst = 1'b1; rptr_gray = '0;
        test_reset();
        test_fill();
        test_release();
        test_reset_mid();
        test_wrap();
`ifdef WAFULL_EN
        test_wafull();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
